// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for load-use, taken branch and mul/div occupancy,
// plus a saturating count of cycles where the PC is frozen.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [31:0] stall_count
);
  typedef enum logic {RUN, MULDIV} state_t;
  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 1);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt;
  logic [31:0] r_stall_count;
  logic        w_lu;
  assign w_lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;
    w_next       = r_state;
    w_cnt        = r_cnt;
    if (!rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      w_next      = RUN;
      w_cnt       = 8'd0;
    end else if (r_state == MULDIV) begin
      // EX holds the mul/div: freeze the front end and feed bubbles forward
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
      muldiv_busy  = 1'b1;
      muldiv_done  = (r_cnt == 8'd1);
      w_cnt        = r_cnt - 8'd1;
      w_next       = (r_cnt == 8'd1) ? RUN : MULDIV;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_muldiv) begin
      w_next = MULDIV;
      w_cnt  = CNT_INIT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= RUN;
      r_cnt         <= 8'd0;
      r_stall_count <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (!pc_write && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; a behavioural model pushes expected outputs as each cycle
// is driven, and each scenario task pops and compares them against the DUT.
module tb_hazard_ctrl;
  localparam int MC = 32;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_muldiv, ex_mem_read, ex_branch_taken;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic        muldiv_busy, muldiv_done;
  logic [31:0] stall_count;
  logic [39:0] w_obs;
  logic [39:0] q[$];
  logic [39:0] e;
  int          passed = 0;
  int          total = 0;
  logic        m_busy, n_busy;
  logic [7:0]  m_cnt, n_cnt;
  logic [31:0] m_stall, n_stall;

  hazard_ctrl #(.MULDIV_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  assign w_obs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                  ex_mem_flush, muldiv_busy, muldiv_done, stall_count};

  // Drives one cycle of inputs and pushes the expected outputs from the reference model.
  task automatic drive(input logic rv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic md, input logic [4:0] ert,
                       input logic mr, input logic br);
    logic       lu;
    logic [7:0] o;
    rst = rv; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_muldiv = md;
    ex_rt = ert; ex_mem_read = mr; ex_branch_taken = br;
    lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    o = 8'b1110_0000;
    n_busy = m_busy;
    n_cnt = m_cnt;
    if (!rv) begin
      o = 8'b0; n_busy = 1'b0; n_cnt = 8'd0;
    end else if (m_busy) begin
      o = {7'b0000_011, m_cnt == 8'd1} | 8'b0000_0100;
      n_cnt = m_cnt - 8'd1;
      n_busy = (m_cnt != 8'd1);
    end else if (br) o = 8'b1111_1000;
    else if (lu) o = 8'b0010_1000;
    else if (md) begin
      n_busy = 1'b1; n_cnt = 8'(MC - 1);
    end
    if (!rv) n_stall = 32'd0;
    else if (!o[7] && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
    else n_stall = m_stall;
    q.push_back({o, m_stall});
  endtask

  task automatic tick;
    @(posedge clk);
    m_busy = n_busy; m_cnt = n_cnt; m_stall = n_stall;
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1; void'(q.pop_front()); tick;
    drive(1, 0, 0, 0, 0, 0, 0, 0); #1; void'(q.pop_front()); tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, 9, 9, 1, 1, 9, i < 2, 0); #1; void'(q.pop_front()); tick;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom));
      #1; e = q.pop_front(); total++;
      if (w_obs !== e) $display("FAIL reset_hold%0d: got %h want %h", i, w_obs, e);
      else passed++;
      tick;
    end
    drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || {pc_write, if_id_write, id_ex_write} !== 3'b111 || stall_count !== 0)
      $display("FAIL reset_release: got %h want %h", w_obs, e);
    else passed++;
    tick;
  endtask

  task automatic test_load_use;
    logic [31:0] s0;
    logic [4:0]  ert [4] = '{8, 0, 8, 8};
    logic [4:0]  rs  [4] = '{8, 0, 1, 1};
    logic        ur  [4] = '{0, 0, 0, 1};
    logic        stl [4] = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      s0 = stall_count;
      drive(1, rs[i], 8, ur[i], 0, ert[i], 1, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e || pc_write !== !stl[i] || id_ex_flush !== stl[i])
        $display("FAIL load_use%0d: got %h want %h", i, w_obs, e);
      else passed++;
      tick;
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e || stall_count !== s0 + 32'(stl[i]))
        $display("FAIL load_use_count%0d: got %h want %h", i, w_obs, e);
      else passed++;
      tick;
    end
  endtask

  task automatic test_branch;
    logic [31:0] s0;
    s0 = stall_count;
    drive(1, 8, 8, 1, 1, 8, 1, 1); #1; e = q.pop_front(); total++;
    if (w_obs !== e || {if_id_flush, id_ex_flush, pc_write} !== 3'b111)
      $display("FAIL branch_prio: got %h want %h", w_obs, e);
    else passed++;
    tick;
    drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || stall_count !== s0 || muldiv_busy !== 1'b0)
      $display("FAIL branch_count: got %h want %h", w_obs, e);
    else passed++;
    tick;
  endtask

  task automatic test_muldiv;
    logic [31:0] s0;
    int busy_n, done_n, done_at, pcz;
    busy_n = 0; done_n = 0; done_at = -1; pcz = 0;
    s0 = stall_count;
    drive(1, 1, 2, 0, 1, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || pc_write !== 1'b1) $display("FAIL muldiv_accept: got %h want %h", w_obs, e);
    else passed++;
    tick;
    for (int c = 1; c <= MC; c++) begin
      drive(1, 8, 8, 1, 1, 8, 1, c == 5); #1; e = q.pop_front(); total++;
      if (w_obs !== e) $display("FAIL muldiv_cyc%0d: got %h want %h", c, w_obs, e);
      else passed++;
      busy_n += int'(muldiv_busy);
      pcz += int'(!pc_write);
      if (muldiv_done) begin done_n++; done_at = c; end
      if (c < MC) tick;
      else begin
        total++;
        if (busy_n != MC - 1 || done_n != 1 || done_at != MC - 1 || pcz != MC - 1 + 1)
          $display("FAIL muldiv_window: busy %0d done %0d@%0d pcz %0d want %0d 1@%0d", busy_n,
                   done_n, done_at, pcz, MC - 1, MC - 1);
        else passed++;
        total++;
        if (stall_count !== s0 + MC - 1)
          $display("FAIL muldiv_stalls: got %0d want %0d", stall_count, s0 + MC - 1);
        else passed++;
        tick;
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 2, 0, 1, 3, 0, 0); #1; void'(q.pop_front()); tick;
    for (int c = 1; c < MC; c++) begin
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e) $display("FAIL b2b_first%0d: got %h want %h", c, w_obs, e);
      else passed++;
      tick;
    end
    drive(1, 1, 2, 0, 1, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || muldiv_busy !== 1'b0) $display("FAIL b2b_accept: got %h want %h", w_obs, e);
    else passed++;
    tick;
    drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || muldiv_busy !== 1'b1) $display("FAIL b2b_busy: got %h want %h", w_obs, e);
    else passed++;
    tick;
    for (int c = 2; c < MC; c++) begin
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; void'(q.pop_front()); tick;
    end
    drive(1, 4, 2, 0, 1, 4, 1, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || pc_write !== 1'b0) $display("FAIL lu_md_stall: got %h want %h", w_obs, e);
    else passed++;
    tick;
    drive(1, 4, 2, 0, 1, 4, 0, 0); #1; void'(q.pop_front()); tick;
    drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e || muldiv_busy !== 1'b1) $display("FAIL lu_md_accept: got %h want %h", w_obs, e);
    else passed++;
    tick;
    for (int c = 2; c < MC; c++) begin
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; void'(q.pop_front()); tick;
    end
  endtask

  task automatic test_reset_mid;
    int done_n;
    done_n = 0;
    drive(1, 1, 2, 0, 1, 3, 0, 0); #1; void'(q.pop_front()); tick;
    for (int c = 1; c < 5; c++) begin
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; void'(q.pop_front()); tick;
    end
    drive(0, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
    if (w_obs !== e) $display("FAIL reset_mid_hold: got %h want %h", w_obs, e);
    else passed++;
    tick;
    for (int c = 0; c < MC + 4; c++) begin
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e || muldiv_busy !== 1'b0 || (c == 0 && stall_count !== 0))
        $display("FAIL reset_mid%0d: got %h want %h", c, w_obs, e);
      else passed++;
      done_n += int'(muldiv_done);
      tick;
    end
    total++;
    if (done_n != 0) $display("FAIL reset_mid_done: got %0d pulses want 0", done_n);
    else passed++;
  endtask

  task automatic test_saturation;
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1 release dut.r_stall_count;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 0, 0, 0, 7, 1, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e) $display("FAIL sat_stall%0d: got %h want %h", i, w_obs, e);
      else passed++;
      tick;
      drive(1, 1, 2, 0, 0, 3, 0, 0); #1; e = q.pop_front(); total++;
      if (w_obs !== e || stall_count !== 32'hFFFF_FFFF)
        $display("FAIL sat_hold%0d: got %h want ffffffff", i, stall_count);
      else passed++;
      tick;
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(49) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom), $urandom_range(9) == 0, 5'($urandom_range(3)),
            $urandom_range(9) < 3, $urandom_range(9) == 0);
      #1; e = q.pop_front(); total++;
      if (w_obs !== e) $display("FAIL random%0d: got %h want %h", c, w_obs, e);
      else passed++;
      tick;
    end
  endtask

  initial begin
    m_busy = 1'b0; m_cnt = 8'd0; m_stall = 32'd0;
    test_reset;
    test_load_use;
    test_branch;
    test_muldiv;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage pipelined CPU. It produces the write-enable inputs of the PC register and the IF/ID and ID/EX pipeline registers, and the flush controls of the IF/ID, ID/EX and EX/MEM registers. It resolves three cases: load-use hazards, taken branches, and multi-cycle mul/div occupancy of EX. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface

- MULDIV_CYCLES, default 32: EX occupancy of one mul/div, in cycles; legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- id_muldiv  in  1  the ID instruction is MULT/MULTU/DIV/DIVU.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  a branch/jump in EX resolved taken this cycle.
- pc_write  out  1  enable of the PC register.
- if_id_write  out  1  enable of the IF/ID register.
- id_ex_write  out  1  enable of the ID/EX register.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- ex_mem_flush  out  1  EX/MEM loads a bubble.
- muldiv_busy  out  1  mul/div occupies EX.
- muldiv_done  out  1  one-cycle pulse, last busy cycle.
- stall_count  out  32  cycles with pc_write=0 since reset; saturates.

## Operation

- FSM states: RUN and MULDIV. Down-counter cnt is 8 bits wide.
- All outputs except stall_count are combinational from the state and the current inputs.
- Load-use condition LU = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- RUN defaults: pc_write=1, if_id_write=1, id_ex_write=1, all flushes 0, muldiv_busy=0, muldiv_done=0.
- RUN, priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. LU and id_muldiv are ignored because the ID instruction is squashed. State stays RUN.
  2. LU: pc_write=0, if_id_write=0, id_ex_flush=1. This inserts exactly one bubble; id_muldiv is ignored this cycle. State stays RUN.
  3. id_muldiv: outputs keep the RUN defaults, so the mul/div enters EX. Next state is MULDIV with cnt = MULDIV_CYCLES-1.
- MULDIV:
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1, muldiv_busy=1.
  - All inputs are ignored, including ex_branch_taken and LU, because EX holds the mul/div.
  - cnt decrements each cycle.
  - When cnt==1: muldiv_done=1, and next state is RUN.
  - Total front-end freeze is MULDIV_CYCLES-1 cycles.
- stall_count increments by 1 on each clock edge where rst=1 and pc_write=0. It holds at 32'hFFFFFFFF; there is no wrap.
- Reset, when rst=0 at an edge:
  - Next state is RUN, cnt=0, stall_count=0.
  - This applies in any state, including mid-MULDIV; the in-flight mul/div is abandoned.
  - While rst=0, the combinational outputs are forced: pc_write=0, if_id_write=0, id_ex_write=0, all flushes 0, muldiv_busy=0, muldiv_done=0.

## Timing

- Zero-cycle decision path: inputs sampled in cycle N drive the outputs in cycle N. The pipeline registers act on the edge that ends cycle N.
- Load-use stall is exactly 1 cycle per hazard. In the following cycle EX holds the bubble (ex_mem_read=0), so LU clears.
- Mul/div: id_muldiv is accepted in cycle N. Cycles N+1..N+MULDIV_CYCLES-1 are MULDIV, and muldiv_done is high in cycle N+MULDIV_CYCLES-1. Cycle N+MULDIV_CYCLES is RUN.
- Back-to-back mul/div: a second id_muldiv in the first RUN cycle after done is accepted immediately.
- Simultaneous ex_branch_taken & LU: the branch wins; there is no stall and stall_count does not change.
- Simultaneous LU & id_muldiv: the stall is taken first, and the mul/div is accepted the next cycle if LU has cleared.
- Reset release: the first cycle with rst=1 is RUN with default outputs.
- stall_count updates one edge after the stalled cycle.

## Test plan

- Reset: hold rst=0 for 3 cycles from random state -> all enables 0, flushes 0, stall_count=0. Release -> pc_write=if_id_write=id_ex_write=1.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle, stall_count goes 0->1. Repeat with ex_rt=0 -> no stall. Repeat with id_rt=8 and id_uses_rt=0 -> no stall.
- Branch priority: ex_branch_taken=1 together with an LU match -> if_id_flush=id_ex_flush=1, pc_write=1, stall_count unchanged.
- Mul/div, MULDIV_CYCLES=32: id_muldiv pulse at cycle 10 -> muldiv_busy high in cycles 11..41, muldiv_done only in cycle 41, pc_write=0 for 31 cycles, stall_count=31. An ex_branch_taken pulse inside the window has no effect.
- Reset mid-MULDIV: rst=0 at busy cycle 5 -> next cycle RUN, muldiv_busy=0, stall_count=0, and no done pulse ever appears.
- Saturation: force stall_count near the top via repeated LU (or a backdoor preload to 32'hFFFFFFFE), then 3 more stalls -> stall_count reaches 32'hFFFFFFFF and holds there.
